deser_nbits: RTL
================

# deser_nbits

Serial-to-parallel loader that assembles N consecutive bits from a 1-bit serial input into an N-bit word. It sits directly upstream of the team's N-bit enabled register stage: `data` drives that register's `d`, and `load` drives its `en`. `load` pulses for exactly one cycle per completed word, so the downstream register captures each word once and holds it until the next word completes.

## Interface
- `N`, default 4: word width in bits; legal range N ≥ 2.
- `MSB_FIRST`, default 1: 1 means the first serial bit lands in `data[N-1]`; 0 means it lands in `data[0]`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `start` in 1: request to begin a frame; honoured only in IDLE or DONE.
- `abort` in 1: synchronous frame cancel; highest priority after `reset`.
- `sin` in 1: serial data; sampled every cycle while in SHIFT.
- `data` out N: assembled word; guaranteed valid only while `load`=1.
- `load` out 1: one-cycle pulse, the downstream register enable.
- `busy` out 1: high while in SHIFT.
- `count` out $clog2(N+1): number of bits captured in the current frame.

## Operation
- The FSM has three states, binary encoded: IDLE=0, SHIFT=1, DONE=2.
- IDLE:
  - `start`=1 → SHIFT, with `count` cleared to 0.
  - Otherwise the FSM stays in IDLE.
- SHIFT:
  - Every cycle, `sin` is shifted into the shift register and `count` increments.
  - MSB_FIRST=1: sr ← {sr[N-2:0], sin}.
  - MSB_FIRST=0: sr ← {sin, sr[N-1:1]}.
  - The edge that captures bit N (`count` goes from N-1 to N) moves the FSM to DONE.
  - `start` is ignored in SHIFT.
- DONE:
  - `load`=1 and `data`=sr.
  - `start`=1 → SHIFT, with `count` cleared. This back-to-back path has no idle gap.
  - Otherwise → IDLE.
- `abort`=1 in any state → IDLE on the next edge. `count` clears to 0, no `load` is issued, and sr is unchanged.
- Priority order: `reset` > `abort` > `start` / normal progression.
- `count` saturates at N in DONE and holds N in IDLE until the next `start`.
- `busy`, `load` and `count` are Moore outputs, decoded from registered state only. No combinational path exists from any input to any output.

## Timing
- Reset values: state=IDLE, sr=0, `count`=0, `data`=0, `load`=0, `busy`=0.
- Latency: `start` is sampled at edge E0, and bits are sampled at edges E1..EN.
- `load`=1 during the cycle between edges EN and EN+1. The downstream register therefore captures at edge EN+1.
- `busy` is high from E0 until EN, i.e. for exactly N cycles.
- Frame throughput: N+1 cycles per word, including the DONE cycle.
- `reset` or `abort` asserted mid-SHIFT: the FSM is in IDLE after that edge and a partial word never produces `load`.
- `abort` and `start` asserted together in IDLE or DONE: `abort` wins and the FSM stays in or enters IDLE.
- `start` held continuously high: frames repeat every N+1 cycles, and each frame produces exactly one `load` pulse.

## Structure
- Shared package `deser_pkg` holds:
  - state localparams `S_IDLE`, `S_SHIFT`, `S_DONE`;
  - state width constant = 2.
- Count width is derived locally as $clog2(N+1).
- One sub-module is natural: `cnt_modn`, a parameterised up-counter with synchronous clear, enable and a terminal-count flag. It provides `count` and the "last bit" condition.
- The shift register and FSM stay in the top module. They use the two-segment style: a registered state block plus combinational next-state and output logic.

## Test plan
- Reset: assert `reset` for 2 cycles with `start`=1 → after release all outputs are 0, state=IDLE, and no `load`.
- MSB-first frame: N=4, MSB_FIRST=1, `start` pulse, then `sin`=1,0,1,1 → `load` pulses one cycle after the 4th bit with `data`=4'b1011, and `busy` is high for 4 cycles.
- LSB-first frame: MSB_FIRST=0, same bit stream → `data`=4'b1101 on the `load` cycle.
- Back-to-back: `start` held high and bits 1,1,0,0 then 0,1,0,1 (MSB_FIRST=1) → `load` pulses exactly 5 cycles apart with `data`=4'b1100 then 4'b0101.
- Abort mid-frame: `abort`=1 after 2 bits → next cycle IDLE, `count`=0, no `load`. A subsequent full frame 1,0,0,1 → `data`=4'b1001.
- Ignored start: `start` pulsed during SHIFT → the frame completes normally with a single `load` and `count`=4 at DONE.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared constants for the serial-to-parallel loader: FSM state encoding.
package deser_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] S_SHIFT = 2'd1;
  localparam logic [STATE_W-1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/deser_nbits_cnt_modn.sv
// Saturating up-counter with synchronous clear and enable. The tc flag marks
// the value one below MAX, i.e. the cycle whose edge captures the last bit.
module cnt_modn #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] TOP  = W'(MAX);
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != TOP)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == LAST);

endmodule

// File: rtl/deser_nbits.sv
// Serial-to-parallel loader: assembles N serial bits into a word and pulses
// load for one cycle per completed word to enable the downstream register.
module deser_nbits
  import deser_pkg::*;
#(
  parameter int N         = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     sin,
  output logic [N-1:0]             data,
  output logic                     load,
  output logic                     busy,
  output logic [$clog2(N+1)-1:0]   count
);

  localparam int CNT_W = $clog2(N + 1);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [N-1:0]       sr_q;
  logic [N-1:0]       sr_d;
  logic               cnt_clr;
  logic               cnt_en;
  logic               cnt_tc;
  logic [CNT_W-1:0]   cnt_val;

  function automatic logic [N-1:0] shift_in(input logic [N-1:0] cur, input logic b);
    if (MSB_FIRST != 0) begin
      return {cur[N-2:0], b};
    end else begin
      return {b, cur[N-1:1]};
    end
  endfunction

  cnt_modn #(
    .MAX (N),
    .W   (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt_val),
    .tc    (cnt_tc)
  );

  // Abort overrides every state; the shift register keeps its contents.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_SHIFT;
            cnt_clr = 1'b1;
          end
        end
        S_SHIFT: begin
          sr_d   = shift_in(sr_q, sin);
          cnt_en = 1'b1;
          if (cnt_tc) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (start) begin
            state_d = S_SHIFT;
            cnt_clr = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
    end
  end

  assign busy  = (state_q == S_SHIFT);
  assign load  = (state_q == S_DONE);
  assign data  = sr_q;
  assign count = cnt_val;

endmodule
